// File: rtl/alu_divider.sv
// Multi-cycle signed integer divider: restoring division on operand magnitudes,
// one quotient bit per clock, followed by a sign-fixup cycle and a result cycle.
module alu_divider #(
    parameter int BITS = 11
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [BITS-1:0] regA,
    input  logic [BITS-1:0] regB,
    input  logic            computestrobe,
    output logic [BITS-1:0] quotient,
    output logic [BITS-1:0] remainder,
    output logic            busy,
    output logic            done,
    output logic            divzero,
    output logic            ovf
);

    localparam int CW = $clog2(BITS + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DIVIDE = 2'd1;
    localparam logic [1:0] S_SIGN   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [BITS-1:0] MOST_NEG = {1'b1, {(BITS-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [BITS:0]   rem_q, rem_d;
    logic [BITS-1:0] dvd_q, dvd_d;
    logic [BITS-1:0] dsr_q, dsr_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_b_q, neg_b_d;
    logic [BITS-1:0] pq_q, pq_d;
    logic [BITS-1:0] pr_q, pr_d;
    logic            pdz_q, pdz_d;
    logic            povf_q, povf_d;
    logic [BITS-1:0] quot_q, quot_d;
    logic [BITS-1:0] remo_q, remo_d;
    logic            dz_q, dz_d;
    logic            ovf_q, ovf_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [BITS:0]   shifted;
    logic [BITS:0]   trial;

    // The partial remainder never exceeds the divisor, so its low BITS bits
    // plus the incoming dividend bit always fit; trial's MSB is its sign.
    assign shifted = {rem_q[BITS-1:0], dvd_q[BITS-1]};
    assign trial   = shifted - {1'b0, dsr_q};

    always_comb begin
        // NOTE: every next-state signal takes its current value first so no
        // path through the case statement can leave one unassigned (no latches).
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        pq_d    = pq_q;
        pr_d    = pr_q;
        pdz_d   = pdz_q;
        povf_d  = povf_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        busy_d  = (state_q == S_DIVIDE) || (state_q == S_SIGN);

        case (state_q)
            S_IDLE: begin
                if (computestrobe) begin
                    neg_a_d = regA[BITS-1];
                    neg_b_d = regB[BITS-1];
                    dvd_d   = regA[BITS-1] ? -regA : regA;
                    dsr_d   = regB[BITS-1] ? -regB : regB;
                    rem_d   = '0;
                    count_d = CW'(BITS);
                    if (regB == '0) begin
                        pq_d    = '0;
                        pr_d    = '0;
                        pdz_d   = 1'b1;
                        povf_d  = 1'b0;
                        state_d = S_FINISH;
                    end else if (regA == MOST_NEG && regB == '1) begin
                        pq_d    = '0;
                        pr_d    = '0;
                        pdz_d   = 1'b0;
                        povf_d  = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_DIVIDE;
                    end
                end
            end
            S_DIVIDE: begin
                if (!trial[BITS]) begin
                    rem_d = trial;
                    dvd_d = {dvd_q[BITS-2:0], 1'b1};
                end else begin
                    rem_d = shifted;
                    dvd_d = {dvd_q[BITS-2:0], 1'b0};
                end
                count_d = count_q - 1'b1;
                if (count_q == CW'(1)) begin
                    state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                pq_d    = (neg_a_q ^ neg_b_q) ? -dvd_q : dvd_q;
                pr_d    = neg_a_q ? -rem_q[BITS-1:0] : rem_q[BITS-1:0];
                pdz_d   = 1'b0;
                povf_d  = 1'b0;
                state_d = S_FINISH;
            end
            default: begin
                quot_d  = pq_q;
                remo_d  = pr_q;
                dz_d    = pdz_q;
                ovf_d   = povf_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples its _d value from the same pre-edge snapshot.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            pq_q    <= '0;
            pr_q    <= '0;
            pdz_q   <= 1'b0;
            povf_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            pq_q    <= pq_d;
            pr_q    <= pr_d;
            pdz_q   <= pdz_d;
            povf_q  <= povf_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign quotient  = quot_q;
    assign remainder = remo_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign divzero   = dz_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/alu_divider.md
Name: alu_divider

Overview:
- Multi-cycle signed integer divider for the calculator datapath; it is the inverse operation of the ALU's Booth multiplier and fills the divide opcode.
- Takes the same 11-bit signed operand registers and produces an 11-bit signed quotient and remainder for the display mux.
- Uses restoring division on operand magnitudes, one quotient bit per clock, then a sign-fixup cycle.
- Has a start strobe, busy level and one-cycle done pulse so the control FSM can sequence it.

Parameters:
- BITS, 11, operand/quotient/remainder width (two's complement); iteration count equals BITS.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- regA  input  BITS  signed dividend.
- regB  input  BITS  signed divisor.
- computestrobe  input  1  start request; sampled only in IDLE.
- quotient  output  BITS  signed quotient, truncated toward zero.
- remainder  output  BITS  signed remainder; sign follows the dividend.
- busy  output  1  high while a division is in progress (not IDLE).
- done  output  1  one-cycle pulse when results and flags update.
- divzero  output  1  last operation had divisor == 0.
- ovf  output  1  last quotient was not representable in BITS.

Behaviour:
- Reset (asynchronous, any time including mid-operation): state=IDLE. quotient, remainder, busy, done, divzero and ovf all return to 0. The counter and working registers clear. Any division in progress is abandoned and produces no done.
- States: IDLE, DIVIDE, SIGN, FINISH.
- IDLE:
  - computestrobe=1 at an edge latches both operand signs, |regA| and |regB| as BITS-bit unsigned values (|-1024|=1024 fits), clears the partial remainder (BITS+1 bits), and sets count=BITS.
  - If regB==0 at that edge: go to FINISH with pending quotient=0, remainder=0, divzero=1, ovf=0.
  - If regA=-2^(BITS-1) and regB=-1 at that edge: go to FINISH with pending 0/0, divzero=0, ovf=1.
  - Otherwise go to DIVIDE.
- DIVIDE, one step per cycle:
  - Shift {rem, dividend} left by 1.
  - trial = rem - divisor. If trial is non-negative, rem=trial and the new quotient LSB=1; else keep rem and quotient LSB=0.
  - Decrement count. When count reaches 0, go to SIGN. This takes exactly BITS cycles.
- SIGN:
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend was negative.
  - Pending divzero=0, ovf=0. Go to FINISH.
- FINISH:
  - Drive quotient, remainder, divzero and ovf from the pending values. done=1 for exactly this edge's cycle. Go to IDLE.
  - Outputs hold until the next FINISH.
- Latency, with the strobe sampled at edge k:
  - Normal operation: done is high in the cycle after edge k+BITS+2, i.e. 13 edges after k for BITS=11.
  - Divide-by-zero and overflow: done is high after edge k+1.
- busy=1 from the edge after strobe acceptance until the edge that asserts done. busy=0 whenever done=1.
- computestrobe while busy is ignored; it is not queued.
- A strobe in the cycle done is high is accepted, since the state is IDLE then. Back-to-back operations are allowed with no dead cycle.
- Operands are captured at acceptance. Changes on regA/regB during DIVIDE do not affect the result.
- Invariant for non-error results: regA == quotient*regB + remainder, with |remainder| < |regB|.

Test Plan:
- Reset, then regA=100, regB=7, strobe for one cycle -> quotient=14, remainder=2, divzero=0, ovf=0. done pulses exactly 13 edges after the strobe edge; busy is high for 12 cycles.
- Sign combinations, each case a separate operation:
  - regA=-100, regB=7 -> q=-14, r=-2.
  - regA=100, regB=-7 -> q=-14, r=2.
  - regA=-100, regB=-7 -> q=14, r=-2.
  - regA=999, regB=-1 -> q=-999, r=0.
- regA=5, regB=0, strobe -> divzero=1, q=0, r=0, done one edge later. A following 6/3 -> q=2, r=0, divzero cleared.
- regA=-1024, regB=-1 -> ovf=1, q=0, r=0, done after one edge. Also regA=-1024, regB=1 -> q=-1024, ovf=0.
- Strobe 500/3, re-strobe 9/9 at cycle 5 -> ignored; result q=166, r=2. Strobe 9/9 in the done cycle -> accepted, q=1, r=0.
- Strobe 999/2, assert reset_n=0 asynchronously at cycle 6 -> all outputs 0 immediately, no done. Release reset, run 999/2 -> q=499, r=1.
